sgen: RTL and testbench
=======================

# sgen

Serial pattern transmitter: accepts a parallel word through a ready/load handshake and shifts it out MSB-first on a single-bit serial line. It drives the serial input of the sequence detector and closes the loop on the test side. It also produces `run`, a cycle-aligned prediction of the detector's "three or more consecutive ones" output, so a bench can compare the two directly.

## Interface
- `WIDTH`, default 8: maximum frame length in bits; width of `data`.
- `LW`, default 4: width of `len`; requires 2^LW > WIDTH.
- `GAP`, default 2: number of forced-zero bits after each frame. 0 is legal.

- `ck`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `load`  in  1  frame request; accepted on a rising edge only while `ready`=1.
- `data`  in  WIDTH  frame bits. The frame is `data[len-1:0]`, sent `data[len-1]` first.
- `len`  in  LW  frame length, valid values 1..WIDTH. 0 means WIDTH. Values above WIDTH are clamped to WIDTH.
- `ready`  out  1  1 when in state IDLE, decoded combinationally from state.
- `busy`  out  1  registered; 1 in states SEND and GAP.
- `so`  out  1  registered serial data output.
- `done`  out  1  registered; one-cycle pulse on return to IDLE after a completed frame.
- `run`  out  1  registered; 1 in cycle t if and only if `so` was 1 in cycles t-1, t-2 and t-3.

## Operation
- **State machine:** IDLE, SEND, GAP. Any unused encoding returns to IDLE.
- **IDLE:**
  - `so`=0, `busy`=0.
  - If `load`=1 at the edge: capture the frame left-justified into the shift register, set the bit counter to the effective `len`, and go to SEND.
- **SEND:**
  - Each cycle, `so` presents the current MSB of the shift register. The register shifts left by one per edge.
  - When the bit counter expires: go to GAP if GAP>0, otherwise go to IDLE.
- **GAP:**
  - `so`=0 for exactly GAP cycles, then go to IDLE.
- **done:**
  - Asserted for exactly one cycle, the first IDLE cycle after a frame.
  - Never asserted after a reset-aborted frame.
- **Handshake:**
  - `load` while `ready`=0 is ignored. It is not queued, and `data`/`len` are not sampled.
  - A `load` in the `done` cycle is accepted, because that cycle is IDLE.
- **run tracking:**
  - A saturating 2-bit count of consecutive ones on `so`: increments when `so`=1, clears when `so`=0.
  - `run` is set from the count of the previous cycles, giving the same 1-cycle lag as the detector sampling `so`.
  - Zeros emitted in GAP and IDLE clear the count.
- **Reset:** while `reset`=0, asynchronously and immediately:
  - state=IDLE, shift register and counters cleared.
  - `so`=0, `busy`=0, `done`=0, `run`=0, `ready`=1.
  - A frame in progress is discarded.
  - `load` is ignored while reset is asserted.

## Timing
- Cycle numbering: the edge that accepts `load` is edge 0. Cycle k is the interval after edge k-1.
- Frame bits appear on `so` in cycles 1..L, where L is the effective length.
- Gap zeros occupy cycles L+1..L+GAP.
- IDLE with `done`=1 is cycle L+GAP+1.
- Minimum load-to-load spacing is L+GAP+1 edges, so there is at least one IDLE zero between frames even when GAP=0.
- Latency from `load` to the first bit is 1 cycle.
- `busy` is high in cycles 1..L+GAP.
- `run` lags the third consecutive one by one cycle and falls one cycle after `so` falls.

## Test plan
- **Reset values:** assert `reset`=0 at any time → `so`=0, `busy`=0, `done`=0, `run`=0, `ready`=1 without waiting for an edge.
- **Full frame with gap:** `data`=8'hB7, `len`=8, GAP=2 →
  - `so`=1,0,1,1,0,1,1,1 in cycles 1-8, then 0,0 in cycles 9-10.
  - `done`=1 only in cycle 11.
  - `run`=1 only in cycle 9.
- **Short frame, no gap:** GAP=0, `data`=8'h07, `len`=3 → `so`=1,1,1 in cycles 1-3; cycle 4 has `so`=0, `ready`=1, `done`=1, `run`=1. Reloading in cycle 4 gives `so`=1 again in cycles 5-7.
- **Load while busy:** `load` pulses in cycles 2 and 5 of an 8-bit frame → no effect; `so` matches the original frame and `done` pulses once.
- **Reset mid-frame:** `reset`=0 in cycle 4 of the 8'hB7 frame → outputs go immediately to reset values and no `done` pulse occurs. After release, loading 8'hFF with `len`=0 → 8 ones in cycles 1-8, with `run`=1 in cycles 4-9.
- **len clamp:** `len`=15, WIDTH=8 → the frame is sent as 8 bits.

Source files
------------

// File: rtl/sgen_if.sv
// Frame handshake and serial-output bundle between a pattern source and its consumer.
// The master side issues frames; the slave side (the transmitter) serialises them.
interface sgen_if #(
   parameter int WIDTH = 8,
   parameter int LW    = 4
) ();
   logic             load;
   logic [WIDTH-1:0] data;
   logic [LW-1:0]    len;
   logic             ready;
   logic             busy;
   logic             so;
   logic             done;
   logic             run;

   modport master (
      output load, data, len,
      input  ready, busy, so, done, run
   );

   modport slave (
      input  load, data, len,
      output ready, busy, so, done, run
   );
endinterface

// File: rtl/sgen.sv
// Serial pattern transmitter: shifts a parallel frame out MSB-first, pads it with GAP zeros,
// and predicts the "three or more consecutive ones" detector output as run.
module sgen #(
   parameter int WIDTH = 8,
   parameter int LW    = 4,
   parameter int GAP   = 2
) (
   input  logic  ck,
   input  logic  reset,
   sgen_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   localparam int            GW       = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
   localparam logic [LW-1:0] WIDTH_L  = LW'(WIDTH);

   function automatic logic [LW-1:0] eff_len(input logic [LW-1:0] l);
      if (l == '0 || l > WIDTH_L) return WIDTH_L;
      return l;
   endfunction

   function automatic logic [1:0] sat_inc(input logic [1:0] c);
      return (c == 2'd3) ? c : c + 2'd1;
   endfunction

   state_t           state, state_nx;
   logic [WIDTH-1:0] shreg, shreg_nx;
   logic [LW-1:0]    cnt, cnt_nx;
   logic [GW-1:0]    gcnt, gcnt_nx;
   logic [1:0]       ones, ones_nx;
   logic             so_bit, so_nx;
   logic             busy_flag, busy_nx;
   logic             done_flag, done_nx;
   logic             run_flag, run_nx;
   logic [LW-1:0]    len_eff;
   logic [WIDTH-1:0] frame_lj;

   always_ff @(posedge ck or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         shreg     <= '0;
         cnt       <= '0;
         gcnt      <= '0;
         ones      <= '0;
         so_bit    <= 1'b0;
         busy_flag <= 1'b0;
         done_flag <= 1'b0;
         run_flag  <= 1'b0;
      end else begin
         state     <= state_nx;
         shreg     <= shreg_nx;
         cnt       <= cnt_nx;
         gcnt      <= gcnt_nx;
         ones      <= ones_nx;
         so_bit    <= so_nx;
         busy_flag <= busy_nx;
         done_flag <= done_nx;
         run_flag  <= run_nx;
      end
   end

   always_comb begin
      state_nx = state;
      shreg_nx = shreg;
      cnt_nx   = cnt;
      gcnt_nx  = gcnt;
      so_nx    = 1'b0;
      busy_nx  = 1'b0;
      done_nx  = 1'b0;
      len_eff  = eff_len(bus.len);
      frame_lj = bus.data << (WIDTH_L - len_eff);

      // cnt counts the bits still to follow the one currently on so
      case (state)
         S_IDLE: begin
            if (bus.load) begin
               state_nx = S_SEND;
               so_nx    = frame_lj[WIDTH-1];
               shreg_nx = frame_lj << 1;
               cnt_nx   = len_eff - 1'b1;
               busy_nx  = 1'b1;
            end
         end
         S_SEND: begin
            busy_nx = 1'b1;
            if (cnt != '0) begin
               so_nx    = shreg[WIDTH-1];
               shreg_nx = shreg << 1;
               cnt_nx   = cnt - 1'b1;
            end else if (GAP > 0) begin
               state_nx = S_GAP;
               gcnt_nx  = GAP_LAST;
            end else begin
               state_nx = S_IDLE;
               busy_nx  = 1'b0;
               done_nx  = 1'b1;
            end
         end
         S_GAP: begin
            if (gcnt == '0) begin
               state_nx = S_IDLE;
               done_nx  = 1'b1;
            end else begin
               busy_nx = 1'b1;
               gcnt_nx = gcnt - 1'b1;
            end
         end
         default: state_nx = S_IDLE;
      endcase

      // ones holds the run length up to the previous cycle, mirroring the detector's sampling lag
      ones_nx = so_bit ? sat_inc(ones) : 2'd0;
      run_nx  = so_bit && (ones >= 2'd2);
   end

   assign bus.ready = (state == S_IDLE);
   assign bus.busy  = busy_flag;
   assign bus.so    = so_bit;
   assign bus.done  = done_flag;
   assign bus.run   = run_flag;
endmodule

// File: tb/tb_sgen.sv
// Bench for sgen: a GAP=2 and a GAP=0 instance driven with fixed and random frames, checked
// per cycle against a frame-level model of the serial stream.
module tb_sgen;
   logic ck;
   logic reset;
   int   tests;
   int   failed;

   logic exp_so    [0:15];
   logic exp_busy  [0:15];
   logic exp_done  [0:15];
   logic exp_run   [0:15];
   logic exp_ready [0:15];
   int   exp_n;
   int   exp_len;

   sgen_if #(.WIDTH(8), .LW(4)) bus2 ();
   sgen_if #(.WIDTH(8), .LW(4)) bus0 ();

   sgen #(.WIDTH(8), .LW(4), .GAP(2)) u2 (.ck(ck), .reset(reset), .bus(bus2));
   sgen #(.WIDTH(8), .LW(4), .GAP(0)) u0 (.ck(ck), .reset(reset), .bus(bus0));

   initial ck = 1'b0;
   always #5 ck = ~ck;

   // Expected stream for one frame, cycle 1 = first bit, cycle exp_n = the done cycle.
   function automatic void build_expect(input logic [7:0] d, input logic [3:0] l, input int gap);
      int L;
      L = (l == 4'd0 || l > 4'd8) ? 8 : int'(l);
      exp_len = L;
      exp_n   = L + gap + 1;
      exp_so[0] = 1'b0;
      for (int k = 1; k <= exp_n; k++) begin
         exp_so[k]    = (k <= L) ? d[L-k] : 1'b0;
         exp_busy[k]  = (k <= L + gap);
         exp_done[k]  = (k == exp_n);
         exp_ready[k] = (k == exp_n);
      end
      for (int k = 1; k <= exp_n; k++)
         exp_run[k] = (k >= 4) && exp_so[k-1] && exp_so[k-2] && exp_so[k-3];
   endfunction

   task automatic test_reset();
      reset = 1'b0;
      bus2.load = 1'b0; bus2.data = '0; bus2.len = '0;
      bus0.load = 1'b0; bus0.data = '0; bus0.len = '0;
      #1;
      tests++; if (bus2.so !== 1'b0)    begin failed++; $display("FAIL reset so got %b exp 0", bus2.so); end
      tests++; if (bus2.busy !== 1'b0)  begin failed++; $display("FAIL reset busy got %b exp 0", bus2.busy); end
      tests++; if (bus2.done !== 1'b0)  begin failed++; $display("FAIL reset done got %b exp 0", bus2.done); end
      tests++; if (bus2.run !== 1'b0)   begin failed++; $display("FAIL reset run got %b exp 0", bus2.run); end
      tests++; if (bus2.ready !== 1'b1) begin failed++; $display("FAIL reset ready got %b exp 1", bus2.ready); end
      tests++; if (bus0.ready !== 1'b1) begin failed++; $display("FAIL reset ready0 got %b exp 1", bus0.ready); end
      repeat (2) @(posedge ck);
      @(negedge ck);
      reset = 1'b1;
      @(negedge ck);
   endtask

   task automatic test_frames();
      logic [7:0] tbl_d [4];
      logic [3:0] tbl_l [4];
      logic [7:0] d;
      logic [3:0] l;
      bit         noise;
      tbl_d = '{8'hB7, 8'h5A, 8'hFF, 8'h3C};
      tbl_l = '{4'd8, 4'd15, 4'd0, 4'd5};
      for (int j = 0; j < 14; j++) begin
         if (j < 4) begin
            d = tbl_d[j]; l = tbl_l[j];
         end else begin
            d = 8'($urandom); l = 4'($urandom_range(0, 15));
         end
         noise = (j % 2 == 0);
         build_expect(d, l, 2);
         bus2.data = d; bus2.len = l; bus2.load = 1'b1;
         for (int k = 1; k <= exp_n; k++) begin
            @(negedge ck);
            bus2.load = 1'b0;
            tests++; if (bus2.so !== exp_so[k])       begin failed++; $display("FAIL frame%0d cyc%0d so got %b exp %b", j, k, bus2.so, exp_so[k]); end
            tests++; if (bus2.busy !== exp_busy[k])   begin failed++; $display("FAIL frame%0d cyc%0d busy got %b exp %b", j, k, bus2.busy, exp_busy[k]); end
            tests++; if (bus2.done !== exp_done[k])   begin failed++; $display("FAIL frame%0d cyc%0d done got %b exp %b", j, k, bus2.done, exp_done[k]); end
            tests++; if (bus2.run !== exp_run[k])     begin failed++; $display("FAIL frame%0d cyc%0d run got %b exp %b", j, k, bus2.run, exp_run[k]); end
            tests++; if (bus2.ready !== exp_ready[k]) begin failed++; $display("FAIL frame%0d cyc%0d ready got %b exp %b", j, k, bus2.ready, exp_ready[k]); end
            // stray requests while busy must be ignored
            if (noise && (k == 2 || k == 5) && k <= exp_len) begin
               bus2.load = 1'b1; bus2.data = ~d; bus2.len = 4'd3;
            end
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      build_expect(8'hB7, 4'd8, 2);
      bus2.data = 8'hB7; bus2.len = 4'd8; bus2.load = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge ck);
         bus2.load = 1'b0;
         tests++; if (bus2.so !== exp_so[k]) begin failed++; $display("FAIL abort cyc%0d so got %b exp %b", k, bus2.so, exp_so[k]); end
      end
      reset = 1'b0;
      #1;
      tests++; if (bus2.so !== 1'b0)    begin failed++; $display("FAIL abort so got %b exp 0", bus2.so); end
      tests++; if (bus2.busy !== 1'b0)  begin failed++; $display("FAIL abort busy got %b exp 0", bus2.busy); end
      tests++; if (bus2.done !== 1'b0)  begin failed++; $display("FAIL abort done got %b exp 0", bus2.done); end
      tests++; if (bus2.run !== 1'b0)   begin failed++; $display("FAIL abort run got %b exp 0", bus2.run); end
      tests++; if (bus2.ready !== 1'b1) begin failed++; $display("FAIL abort ready got %b exp 1", bus2.ready); end
      bus2.load = 1'b1; bus2.data = 8'hFF; bus2.len = 4'd8;
      repeat (2) @(posedge ck);
      @(negedge ck);
      tests++; if (bus2.busy !== 1'b0) begin failed++; $display("FAIL load_in_reset busy got %b exp 0", bus2.busy); end
      reset = 1'b1;
      bus2.load = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge ck);
         tests++; if (bus2.done !== 1'b0) begin failed++; $display("FAIL abort_nodone cyc%0d done got %b exp 0", k, bus2.done); end
         tests++; if (bus2.so !== 1'b0)   begin failed++; $display("FAIL abort_idle cyc%0d so got %b exp 0", k, bus2.so); end
      end
      build_expect(8'hFF, 4'd0, 2);
      bus2.data = 8'hFF; bus2.len = 4'd0; bus2.load = 1'b1;
      for (int k = 1; k <= exp_n; k++) begin
         @(negedge ck);
         bus2.load = 1'b0;
         tests++; if (bus2.so !== exp_so[k])     begin failed++; $display("FAIL ff cyc%0d so got %b exp %b", k, bus2.so, exp_so[k]); end
         tests++; if (bus2.run !== exp_run[k])   begin failed++; $display("FAIL ff cyc%0d run got %b exp %b", k, bus2.run, exp_run[k]); end
         tests++; if (bus2.done !== exp_done[k]) begin failed++; $display("FAIL ff cyc%0d done got %b exp %b", k, bus2.done, exp_done[k]); end
      end
   endtask

   task automatic test_no_gap();
      logic [7:0] d;
      logic [3:0] l;
      for (int j = 0; j < 8; j++) begin
         if (j < 2) begin
            d = 8'h07; l = 4'd3;
         end else begin
            d = 8'($urandom); l = 4'($urandom_range(0, 15));
         end
         build_expect(d, l, 0);
         // each frame is requested in the done cycle of the previous one
         bus0.data = d; bus0.len = l; bus0.load = 1'b1;
         for (int k = 1; k <= exp_n; k++) begin
            @(negedge ck);
            bus0.load = 1'b0;
            tests++; if (bus0.so !== exp_so[k])       begin failed++; $display("FAIL nogap%0d cyc%0d so got %b exp %b", j, k, bus0.so, exp_so[k]); end
            tests++; if (bus0.busy !== exp_busy[k])   begin failed++; $display("FAIL nogap%0d cyc%0d busy got %b exp %b", j, k, bus0.busy, exp_busy[k]); end
            tests++; if (bus0.done !== exp_done[k])   begin failed++; $display("FAIL nogap%0d cyc%0d done got %b exp %b", j, k, bus0.done, exp_done[k]); end
            tests++; if (bus0.run !== exp_run[k])     begin failed++; $display("FAIL nogap%0d cyc%0d run got %b exp %b", j, k, bus0.run, exp_run[k]); end
            tests++; if (bus0.ready !== exp_ready[k]) begin failed++; $display("FAIL nogap%0d cyc%0d ready got %b exp %b", j, k, bus0.ready, exp_ready[k]); end
         end
      end
   endtask

   initial begin
      tests  = 0;
      failed = 0;
      test_reset();
      test_frames();
      test_reset_mid_frame();
      test_no_gap();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
